// File: rtl/arith_pkg.sv
// Shared arithmetic constants and the sequencer state type for the clocked
// arithmetic path (sub32_seq and neighbours).
package arith_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SLICE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder slice.
// Ports:
//   a, b : 4-bit addends
//   ci   : carry in
//   s    : 4-bit sum
//   co   : carry out
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:1] c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ {c[3:1], ci};
    co   = c[4];
  end

endmodule

// File: rtl/sub32_seq.sv
// Sequential subtractor: d = a - b - bi, one SLICE-bit slice per clock,
// LSB slice first, through a single shared cla4 slice fed with ~b.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; discards any operation in flight
//   start  : request, sampled only in IDLE
//   a, b   : minuend / subtrahend, captured on accepted start
//   bi     : borrow in, captured on accepted start
//   d      : registered difference, valid from done until the next start
//   bo     : borrow out (a < b + bi, unsigned)
//   busy   : high in RUN and DONE
//   done   : one-cycle pulse when d/bo become valid
//   ov     : signed overflow, present only with SUB32_OVERFLOW_FLAG_EN
// Build option: `define SUB32_OVERFLOW_FLAG_EN adds the ov output.
module sub32_seq
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = arith_pkg::WIDTH,
  parameter int unsigned SLICE = arith_pkg::SLICE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             busy,
  output logic             done
`ifdef SUB32_OVERFLOW_FLAG_EN
  ,
  output logic             ov
`endif
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               c_q, c_d;
  logic               bo_q, bo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SUB32_OVERFLOW_FLAG_EN
  logic               ov_q, ov_d;
`endif

  logic [SLICE-1:0]   sl_a;
  logic [SLICE-1:0]   sl_b;
  logic [SLICE-1:0]   sl_s;
  logic               sl_co;

  // Subtraction as a + ~b + carry, with the carry seeded to ~bi.
  assign sl_a = a_q[cnt_q*SLICE +: SLICE];
  assign sl_b = ~b_q[cnt_q*SLICE +: SLICE];

  cla4 u_cla4 (
    .a  (sl_a),
    .b  (sl_b),
    .ci (c_q),
    .s  (sl_s),
    .co (sl_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    bo_d    = bo_q;
`ifdef SUB32_OVERFLOW_FLAG_EN
    ov_d    = ov_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = ~bi;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        d_d[cnt_q*SLICE +: SLICE] = sl_s;
        c_d = sl_co;
        if (cnt_q == LAST) begin
          // Counter parks on the last slice rather than wrapping.
          bo_d    = ~sl_co;
`ifdef SUB32_OVERFLOW_FLAG_EN
          ov_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sl_s[SLICE-1] != a_q[WIDTH-1]);
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUB32_OVERFLOW_FLAG_EN
      ov_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      bo_q    <= bo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SUB32_OVERFLOW_FLAG_EN
      ov_q    <= ov_d;
`endif
    end
  end

  assign d    = d_q;
  assign bo   = bo_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef SUB32_OVERFLOW_FLAG_EN
  assign ov   = ov_q;
`endif

endmodule

// File: tb/tb_sub32_seq.sv
module tb_sub32_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        bi_i = 1'b0;
  logic [31:0] d;
  logic        bo;
  logic        busy;
  logic        done;
  logic        ov_s;
`ifdef SUB32_OVERFLOW_FLAG_EN
  logic        ov;
  assign ov_s = ov;
`else
  assign ov_s = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  sub32_seq #(.WIDTH(32), .SLICE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a_i),
    .b     (b_i),
    .bi    (bi_i),
    .d     (d),
    .bo    (bo),
    .busy  (busy),
    .done  (done)
`ifdef SUB32_OVERFLOW_FLAG_EN
    ,
    .ov    (ov)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Issue one start and watch 14 cycles; optionally re-pulse start mid-RUN.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic tbi,
                       input int repulse_at,
                       output int done_idx, output int busy_cnt, output int done_cnt,
                       output logic [31:0] d_at_done, output logic bo_at_done,
                       output logic ov_at_done);
    @(posedge clk); #1;
    a_i = ta; b_i = tb; bi_i = tbi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a_i = ~ta; b_i = ~tb; bi_i = ~tbi;
    done_idx = -1; busy_cnt = 0; done_cnt = 0;
    d_at_done = 'x; bo_at_done = 1'bx; ov_at_done = 1'bx;
    for (int i = 0; i < 14; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_idx < 0) begin
          done_idx = i; d_at_done = d; bo_at_done = bo; ov_at_done = ov_s;
        end
      end
      if (i == repulse_at) begin
        start = 1'b1; a_i = 32'hDEADBEEF; b_i = 32'h1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic        bi;
    int          rep;
    logic [31:0] d;
    logic        bo;
    logic        ov;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int          di, bc, dc;
    logic [31:0] dd;
    logic        bb, oo;

    vecs.push_back('{"a_minus_3",   32'h0000000A, 32'h00000003, 1'b0, -1, 32'h00000007, 1'b0, 1'b0});
    vecs.push_back('{"zero_minus1", 32'h00000000, 32'h00000001, 1'b0, -1, 32'hFFFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{"min_minus1",  32'h80000000, 32'h00000001, 1'b0, -1, 32'h7FFFFFFF, 1'b0, 1'b1});
    vecs.push_back('{"eq_bi1",      32'h12345678, 32'h12345678, 1'b1, -1, 32'hFFFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{"ripple",      32'h10000000, 32'h00000001, 1'b0, -1, 32'h0FFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{"pos_m_neg",   32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, -1, 32'h80000000, 1'b1, 1'b1});
    vecs.push_back('{"one_m_all",   32'h00000001, 32'hFFFFFFFF, 1'b0, -1, 32'h00000002, 1'b1, 1'b0});
    vecs.push_back('{"all_m_all",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1, 32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{"restart_ign", 32'h00000100, 32'h00000001, 1'b0,  3, 32'h000000FF, 1'b0, 1'b0});

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_d", d, 0);
    check("rst_bo", bo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ov", ov_s, 0);
    reset = 1'b0;

    foreach (vecs[k]) begin
      do_op(vecs[k].a, vecs[k].b, vecs[k].bi, vecs[k].rep, di, bc, dc, dd, bb, oo);
      check({vecs[k].tag, "_done_idx"}, 64'(di), 64'(8));
      check({vecs[k].tag, "_busy_cycles"}, 64'(bc), 64'(9));
      check({vecs[k].tag, "_done_pulses"}, 64'(dc), 64'(1));
      check({vecs[k].tag, "_d"}, dd, vecs[k].d);
      check({vecs[k].tag, "_bo"}, bb, vecs[k].bo);
`ifdef SUB32_OVERFLOW_FLAG_EN
      check({vecs[k].tag, "_ov"}, oo, vecs[k].ov);
`endif
      check({vecs[k].tag, "_d_hold"}, d, vecs[k].d);
      check({vecs[k].tag, "_bo_hold"}, bo, vecs[k].bo);
      check({vecs[k].tag, "_idle"}, busy, 0);
    end

    // Reset during the 4th RUN cycle discards the operation.
    @(posedge clk); #1;
    a_i = 32'hFFFFFFFF; b_i = 32'h12345678; bi_i = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_d", d, 0);
    check("midrst_bo", bo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_ov", ov_s, 0);
    dc = 0; bc = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dc++;
      if (busy) bc++;
      @(posedge clk); #1;
    end
    check("midrst_no_done", 64'(dc), 64'(0));
    check("midrst_no_busy", 64'(bc), 64'(0));

    do_op(32'h5, 32'h5, 1'b0, -1, di, bc, dc, dd, bb, oo);
    check("post_rst_done_idx", 64'(di), 64'(8));
    check("post_rst_done_pulses", 64'(dc), 64'(1));
    check("post_rst_d", dd, 32'h0);
    check("post_rst_bo", bb, 1'b0);
`ifdef SUB32_OVERFLOW_FLAG_EN
    check("post_rst_ov", oo, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sub32_seq.md
Name: sub32_seq

Overview:
- Sequential 32-bit subtractor; computes d = a - b - bi one 4-bit slice per clock, LSB slice first.
- Datapath per slice: a 4-bit carry-lookahead slice fed with inverted b and an internal carry.
- Sits in the clocked arithmetic path beside the 32-bit CLA adder; uses a start/busy/done handshake instead of being purely combinational.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle.
- NSLICE, WIDTH/SLICE (8), derived local constant; number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- bi  input  1  borrow-in; captured on accepted start
- d  output  WIDTH  difference; registered
- bo  output  1  borrow-out (1 when a < b + bi, unsigned)
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; d/bo valid from this cycle

Behaviour:
- Reset (sync, active-high): state=IDLE, d=0, bo=0, busy=0, done=0, slice counter=0, internal operand registers=0. Reset overrides every other input, including mid-RUN; the operation in flight is discarded and no done pulse is produced.
- IDLE: if start=1, capture a, b, and carry = ~bi. Clear the counter. Go to RUN. Otherwise hold d/bo from the last result.
- RUN: each cycle compute slice k = counter:
  - d[k*4+3:k*4] = a_k + ~b_k + carry.
  - Carry register is updated to the slice carry-out.
  - Counter increments.
  - When counter = NSLICE-1, write the final slice and set bo = ~carry_out. Go to DONE.
- DONE: done=1 for exactly this cycle, busy=1. Next cycle go to IDLE with busy=0.
- Latency: start sampled at edge N; done is high during the cycle after edge N+8 (9 edges start-to-done). Throughput is one operation per 10 cycles.
- start outside IDLE (RUN/DONE) is ignored, not queued. Captured operands are immune to input changes after capture.
- d is undefined-but-stable (partially updated) during RUN. Consumers use d/bo only from done onward. They remain stable until the next accepted start.
- Arithmetic: modulo 2^WIDTH. Examples: 0 - 1 gives d=FFFFFFFF, bo=1; bi=1 with a=b gives d=FFFFFFFF, bo=1.
- Counter width is clog2(NSLICE). No wrap occurs, because RUN exits at NSLICE-1.

Optional Feature:
- Macro SUB32_OVERFLOW_FLAG_EN.
- Defined:
  - Adds output port ov (1 bit), registered with bo.
  - ov = signed overflow, i.e. a[31] != b[31] and d[31] != a[31].
  - Reset value 0.
- Undefined: the port is absent and no overflow logic is synthesized.

Decomposition:
- Shared package arith_pkg holds:
  - constants WIDTH=32, SLICE=4;
  - state typedef {IDLE, RUN, DONE} with 2-bit encoding 00/01/10.
- One sub-module: the existing 4-bit CLA slice (cla4), instantiated once.
  - Wiring: a = a slice, b = ~b slice, ci = carry register, s = d slice, co = next carry.
- Slice selection is by counter-indexed part-select on the captured operand registers.

Test Plan:
- a=0x0000000A, b=0x00000003, bi=0, start pulse -> done after 9 edges; d=0x00000007, bo=0, busy high for exactly 9 cycles.
- a=0x00000000, b=0x00000001, bi=0 -> d=0xFFFFFFFF, bo=1; with SUB32_OVERFLOW_FLAG_EN, ov=0.
- a=0x80000000, b=0x00000001, bi=0 -> d=0x7FFFFFFF, bo=0; ov=1 (feature enabled).
- a=0x12345678, b=0x12345678, bi=1 -> d=0xFFFFFFFF, bo=1.
- Start issued, then a/b changed and start re-pulsed during RUN -> result matches the first operands only; exactly one done pulse.
- Reset asserted at the 4th RUN cycle -> next cycle all outputs 0, state IDLE, no done pulse; a fresh start then completes correctly (a=5, b=5, bi=0 -> d=0, bo=0).
